// File: rtl/xoodoo_nc_iter.sv
// Iterated 96-bit Xoodoo-style permutation; emits CONCAT_FACTOR chained 96-bit digest blocks.
// Define XOODOO_NC_ABORT_EN to add an abort input that cancels a call in RUN or DONE.
module xoodoo_nc_iter #(
    parameter int ROUNDS          = 3,
    parameter int UNROLL          = 1,
    parameter int CONCAT_FACTOR   = 1,
    localparam int HASH_SIZE      = 96 * CONCAT_FACTOR
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef XOODOO_NC_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [95:0]          state,
    output logic [HASH_SIZE-1:0] out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int unsigned UNROLL_U = UNROLL;
    localparam int unsigned CF_U     = CONCAT_FACTOR;
    localparam logic [3:0]  ROUNDS_L = 4'(ROUNDS);
    localparam logic [3:0]  UNROLL_L = 4'(UNROLL);
    localparam logic [3:0]  RC_BASE  = 4'(12 - ROUNDS);
    localparam logic [1:0]  LAST_BLK = 2'(CONCAT_FACTOR - 1);

    logic [1:0]           fsm_q, fsm_d;
    logic [95:0]          work_q, work_d;
    logic [3:0]           rnd_q, rnd_d;
    logic [1:0]           blk_q, blk_d;
    logic [HASH_SIZE-1:0] out_q, out_d;
    logic [95:0]          perm_w;
    logic                 abort_w;

`ifdef XOODOO_NC_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] rc_of(input logic [3:0] idx);
        case (idx)
            4'd0:    rc_of = 32'h058;
            4'd1:    rc_of = 32'h038;
            4'd2:    rc_of = 32'h3C0;
            4'd3:    rc_of = 32'h0D0;
            4'd4:    rc_of = 32'h120;
            4'd5:    rc_of = 32'h014;
            4'd6:    rc_of = 32'h060;
            4'd7:    rc_of = 32'h02C;
            4'd8:    rc_of = 32'h380;
            4'd9:    rc_of = 32'h0F0;
            4'd10:   rc_of = 32'h1A0;
            4'd11:   rc_of = 32'h012;
            default: rc_of = '0;
        endcase
    endfunction

    function automatic logic [95:0] xround(input logic [95:0] s, input logic [31:0] rc);
        logic [31:0] a0, a1, a2, p, e, b0, b1, b2;
        a0 = s[31:0];
        a1 = s[63:32];
        a2 = s[95:64];
        p  = a0 ^ a1 ^ a2;
        e  = rol(p, 5) ^ rol(p, 14);
        a0 = a0 ^ e;
        a1 = a1 ^ e;
        a2 = rol(a2 ^ e, 11);
        a0 = a0 ^ rc;
        b0 = ~a1 & a2;
        b1 = ~a2 & a0;
        b2 = ~a0 & a1;
        a0 = a0 ^ b0;
        a1 = rol(a1 ^ b1, 1);
        a2 = rol(a2 ^ b2, 8);
        return {a2, a1, a0};
    endfunction

    always_comb begin
        perm_w = work_q;
        for (int unsigned u = 0; u < UNROLL_U; u++) begin
            perm_w = xround(perm_w, rc_of(RC_BASE + rnd_q + 4'(u)));
        end
    end

    always_comb begin
        fsm_d  = fsm_q;
        work_d = work_q;
        rnd_d  = rnd_q;
        blk_d  = blk_q;
        out_d  = out_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d = state;
                    rnd_d  = '0;
                    blk_d  = '0;
                    fsm_d  = S_RUN;
                end
            end
            S_RUN: begin
                work_d = perm_w;
                rnd_d  = rnd_q + UNROLL_L;
                if (rnd_d == ROUNDS_L) begin
                    // Block boundary: capture digest block, keep permuting the same state
                    rnd_d = '0;
                    for (int unsigned k = 0; k < CF_U; k++) begin
                        if (blk_q == 2'(k)) out_d[96*k +: 96] = perm_w;
                    end
                    if (blk_q == LAST_BLK) fsm_d = S_DONE;
                    else                   blk_d = blk_q + 2'd1;
                end
            end
            S_DONE: begin
                if (out_ready) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
        if (abort_w && (fsm_q != S_IDLE)) begin
            fsm_d = S_IDLE;
            out_d = out_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= S_IDLE;
            work_q <= '0;
            rnd_q  <= '0;
            blk_q  <= '0;
            out_q  <= '0;
        end else begin
            fsm_q  <= fsm_d;
            work_q <= work_d;
            rnd_q  <= rnd_d;
            blk_q  <= blk_d;
            out_q  <= out_d;
        end
    end

    assign in_ready  = (fsm_q == S_IDLE);
    assign busy      = (fsm_q == S_RUN);
    assign out_valid = (fsm_q == S_DONE);
    assign out       = out_q;

endmodule
